instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Instruction-memory model that answers the fetcher's memory fetch interface: accepts a PC-addressed request, waits a programmable latency, then returns the instruction word.
- Sits opposite the fetcher. Port names match the fetcher's so the two wire together by name.
- Includes a side load port for preloading the program from a bench or host.
- Used in fetcher/core simulation and as a synthesizable program ROM/RAM.

Parameters:
- PC_ADDR_WIDTH, 8, request address width.
- INST_MSG_WIDTH, 16, instruction word width.
- DEPTH, 256, number of implemented words; must satisfy 1 <= DEPTH <= 2^PC_ADDR_WIDTH.
- LATENCY, 2, cycles from request accept to response valid; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_req_val  input  1  fetch request valid.
- fetch_req_rdy  output  1  responder can accept a request.
- fetch_req_addr  input  PC_ADDR_WIDTH  instruction address (PC).
- fetch_resp_val  output  1  response valid.
- fetch_resp_rdy  input  1  requester accepts the response.
- fetch_resp_inst  output  INST_MSG_WIDTH  instruction word.
- load_val  input  1  write enable for preload.
- load_addr  input  PC_ADDR_WIDTH  preload address.
- load_data  input  INST_MSG_WIDTH  preload data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Memory array: DEPTH x INST_MSG_WIDTH. It is not cleared by reset; contents survive reset.
- Load port:
  - A write occurs on each rising edge with load_val=1 and load_addr < DEPTH, in any state, including during reset.
  - A load with load_addr >= DEPTH is ignored.
- FSM states: IDLE, WAIT, RESP.
  - Reset asynchronously forces IDLE, cnt=0, fetch_resp_inst=0.
  - Reset-state outputs: fetch_req_rdy=1, fetch_resp_val=0, busy=0.
- IDLE:
  - fetch_req_rdy=1, fetch_resp_val=0.
  - Request accepted on a rising edge with fetch_req_val & fetch_req_rdy.
  - On accept, the read data register captures mem[fetch_req_addr], or 0 if fetch_req_addr >= DEPTH (out-of-range reads return 0, no error flag).
  - If LATENCY==1, go to RESP. Otherwise go to WAIT with cnt=LATENCY-2.
- WAIT:
  - fetch_req_rdy=0, fetch_resp_val=0.
  - Each cycle: if cnt==0 go to RESP, else cnt decrements.
- RESP:
  - fetch_req_rdy=0, fetch_resp_val=1, fetch_resp_inst = captured word, held stable.
  - When fetch_resp_rdy=1 on a rising edge, the handshake completes and the FSM goes to IDLE.
  - fetch_resp_val stays high indefinitely while fetch_resp_rdy=0 (backpressure); inst must not change.
- Latency:
  - Accept edge at cycle t; fetch_resp_val first high in cycle t+LATENCY.
  - Minimum request-to-request spacing is LATENCY+1 cycles when fetch_resp_rdy is held high.
- fetch_resp_inst outside RESP holds its last captured value. It is 0 after reset; the bench must not check it then.
- Simultaneous load and accept to the same address: read-before-write; the response returns the old word, and the new word is visible to later requests.
- A load to an address already captured (WAIT/RESP) does not alter the in-flight response.
- fetch_req_addr is sampled only on the accept edge. fetch_req_val held high in WAIT/RESP has no effect.
- Reset mid-operation (WAIT or RESP):
  - Outputs return to reset values immediately (combinationally via async reset).
  - The in-flight response is dropped; memory contents are intact.
- No combinational path from fetch_req_val/fetch_req_addr to any output; all outputs are state-derived.

Test Plan:
- Preload mem[0..3]=16'h1111,16'h2222,16'h3333,16'h4444 via load port; request addr 2 with fetch_resp_rdy=1, LATENCY=2 -> fetch_req_rdy drops the cycle after accept; fetch_resp_val high exactly 2 cycles after accept edge with inst 16'h3333 for one cycle; fetch_req_rdy=1 next cycle.
- Backpressure: request addr 1, hold fetch_resp_rdy=0 for 5 cycles after fetch_resp_val rises -> val and inst=16'h2222 stable all 5 cycles, fetch_req_rdy=0 throughout; deasserted one cycle after fetch_resp_rdy=1.
- Read-before-write: same edge accept addr 3 and load addr 3 data 16'hBEEF -> response 16'h4444; next request addr 3 -> 16'hBEEF.
- Out of range with DEPTH=4: load addr 8 data 16'hDEAD is ignored; request addr 8 -> response 16'h0000 after LATENCY cycles.
- Reset in WAIT: assert reset between clock edges one cycle after accept -> fetch_resp_val=0, fetch_req_rdy=1, busy=0 immediately; after release, request addr 0 -> 16'h1111 (memory preserved).
- Back-to-back with LATENCY=1 and fetcher connected, fetch_resp_rdy=1: fetch 4 sequential PCs 0..3 -> instructions 1111,2222,3333,4444 in order, each response 1 cycle after accept, accepts spaced 2 cycles apart.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: captures mem[pc] on request accept and presents it LATENCY cycles later.
// Backpressure: the response is held stable until fetch_resp_rdy, and no request is accepted while one is in flight.
module instr_mem_responder #(
  parameter int PC_ADDR_WIDTH  = 8,
  parameter int INST_MSG_WIDTH = 16,
  parameter int DEPTH          = 256,
  parameter int LATENCY        = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_req_val,
  output logic                      fetch_req_rdy,
  input  logic [PC_ADDR_WIDTH-1:0]  fetch_req_addr,
  output logic                      fetch_resp_val,
  input  logic                      fetch_resp_rdy,
  output logic [INST_MSG_WIDTH-1:0] fetch_resp_inst,
  input  logic                      load_val,
  input  logic [PC_ADDR_WIDTH-1:0]  load_addr,
  input  logic [INST_MSG_WIDTH-1:0] load_data,
  output logic                      busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [PC_ADDR_WIDTH:0] DEPTH_L = (PC_ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [INST_MSG_WIDTH-1:0] mem [DEPTH];

  logic load_hit;
  logic req_hit;
  logic accept;

  assign load_hit = load_val && ({1'b0, load_addr} < DEPTH_L);
  assign req_hit  = {1'b0, fetch_req_addr} < DEPTH_L;
  assign accept   = fetch_req_val && fetch_req_rdy;

  // No reset on the array: program contents must survive a core reset.
  always_ff @(posedge clk) begin
    if (load_hit) begin
      mem[load_addr[IDX_W-1:0]] <= load_data;
    end
  end

  // Captured on the accept edge, so a same-edge load is seen only by later requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_resp_inst <= '0;
    end else if (accept) begin
      fetch_resp_inst <= req_hit ? mem[fetch_req_addr[IDX_W-1:0]] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fetch_req_rdy  = 1'b0;
    fetch_resp_val = 1'b0;
    busy           = 1'b1;
    case (state_q)
      IDLE: begin
        fetch_req_rdy = 1'b1;
        busy          = 1'b0;
        if (fetch_req_val) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        fetch_resp_val = 1'b1;
        if (fetch_resp_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: instance A (DEPTH=4, LATENCY=2) and instance B (DEPTH=256, LATENCY=1).
// A transaction-level model is compared on every falling edge; directed tests add literal expectations.
module tb_instr_mem_responder;
  localparam int AW = 8;
  localparam int IW = 16;
  localparam int A_DEPTH = 4;
  localparam int A_LAT = 2;
  localparam int B_DEPTH = 256;
  localparam int B_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst = 1'b1, b_rst = 1'b1;
  logic          a_req_val = 0, a_req_rdy, a_resp_val, a_resp_rdy = 1, a_load_val = 0, a_busy;
  logic [AW-1:0] a_req_addr = '0, a_load_addr = '0;
  logic [IW-1:0] a_resp_inst, a_load_data = '0;
  logic          b_req_val = 0, b_req_rdy, b_resp_val, b_resp_rdy = 1, b_load_val = 0, b_busy;
  logic [AW-1:0] b_req_addr = '0, b_load_addr = '0;
  logic [IW-1:0] b_resp_inst, b_load_data = '0;

  instr_mem_responder #(.PC_ADDR_WIDTH(AW), .INST_MSG_WIDTH(IW), .DEPTH(A_DEPTH), .LATENCY(A_LAT)) u_a (
    .clk(clk), .reset(a_rst),
    .fetch_req_val(a_req_val), .fetch_req_rdy(a_req_rdy), .fetch_req_addr(a_req_addr),
    .fetch_resp_val(a_resp_val), .fetch_resp_rdy(a_resp_rdy), .fetch_resp_inst(a_resp_inst),
    .load_val(a_load_val), .load_addr(a_load_addr), .load_data(a_load_data), .busy(a_busy)
  );

  instr_mem_responder #(.PC_ADDR_WIDTH(AW), .INST_MSG_WIDTH(IW), .DEPTH(B_DEPTH), .LATENCY(B_LAT)) u_b (
    .clk(clk), .reset(b_rst),
    .fetch_req_val(b_req_val), .fetch_req_rdy(b_req_rdy), .fetch_req_addr(b_req_addr),
    .fetch_resp_val(b_resp_val), .fetch_resp_rdy(b_resp_rdy), .fetch_resp_inst(b_resp_inst),
    .load_val(b_load_val), .load_addr(b_load_addr), .load_data(b_load_data), .busy(b_busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  // Model: one in-flight transaction per instance, tracked by edges elapsed since accept.
  logic [IW-1:0] m_mem [2][256];
  bit            m_fly [2] = '{0, 0};
  int            m_age [2] = '{0, 0};
  logic [IW-1:0] m_word[2] = '{16'h0, 16'h0};

  task automatic model_edge(input int k, input int depth, input int lat, input logic rst,
                            input logic rv, input logic [AW-1:0] ra, input logic rr,
                            input logic lv, input logic [AW-1:0] la, input logic [IW-1:0] ld);
    if (rst) m_fly[k] = 0;
    else if (m_fly[k] && m_age[k] >= lat) begin
      if (rr) m_fly[k] = 0;
    end else if (m_fly[k]) m_age[k]++;
    else if (rv) begin
      m_fly[k]  = 1;
      m_age[k]  = 1;
      m_word[k] = (int'(ra) < depth) ? m_mem[k][ra] : '0;
    end
    if (lv && int'(la) < depth) m_mem[k][la] = ld;
  endtask

  always @(posedge clk) model_edge(0, A_DEPTH, A_LAT, a_rst, a_req_val, a_req_addr, a_resp_rdy,
                                   a_load_val, a_load_addr, a_load_data);
  always @(posedge clk) model_edge(1, B_DEPTH, B_LAT, b_rst, b_req_val, b_req_addr, b_resp_rdy,
                                   b_load_val, b_load_addr, b_load_data);
  always @(posedge a_rst) m_fly[0] = 0;
  always @(posedge b_rst) m_fly[1] = 0;

  task automatic chk_outs(input int k, input int lat, input logic rdy, input logic val,
                          input logic bsy, input logic [IW-1:0] inst);
    logic ev;
    ev = m_fly[k] && m_age[k] >= lat;
    chk($sformatf("model_rdy%0d", k), {15'b0, rdy}, {15'b0, !m_fly[k]});
    chk($sformatf("model_val%0d", k), {15'b0, val}, {15'b0, ev});
    chk($sformatf("model_busy%0d", k), {15'b0, bsy}, {15'b0, m_fly[k]});
    if (ev) chk($sformatf("model_inst%0d", k), inst, m_word[k]);
  endtask

  always @(negedge clk) begin
    chk_outs(0, A_LAT, a_req_rdy, a_resp_val, a_busy, a_resp_inst);
    chk_outs(1, B_LAT, b_req_rdy, b_resp_val, b_busy, b_resp_inst);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on A; returns the word and latency (1 = valid right after the accept edge).
  task automatic req_a(input logic [AW-1:0] addr, output logic [IW-1:0] inst, output int lat);
    a_req_val  = 1'b1;
    a_req_addr = addr;
    tick();
    a_req_val  = 1'b0;
    a_load_val = 1'b0;
    lat = 1;
    while (!a_resp_val && lat < 20) begin
      tick();
      lat++;
    end
    inst = a_resp_inst;
  endtask

  logic [IW-1:0] prog [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  initial begin
    logic [IW-1:0] inst;
    int lat;
    int acc_cyc[4];
    int rsp_cyc[4];
    logic [IW-1:0] rsp_inst[4];
    int pc, got, cyc;
    logic acc;

    tick();
    chk("rst_rdy", {15'b0, a_req_rdy}, 16'd1);
    chk("rst_val", {15'b0, a_resp_val}, 16'd0);
    chk("rst_busy", {15'b0, a_busy}, 16'd0);

    // Preload both instances while still in reset.
    for (int i = 0; i < 4; i++) begin
      a_load_val = 1; a_load_addr = AW'(i); a_load_data = prog[i];
      b_load_val = 1; b_load_addr = AW'(i); b_load_data = prog[i];
      tick();
    end
    b_load_val = 0;
    a_load_addr = 8'd8; a_load_data = 16'hDEAD;
    tick();
    a_load_val = 0;
    a_rst = 0; b_rst = 0;
    tick();

    // Basic fetch with LATENCY=2.
    a_req_val = 1; a_req_addr = 8'd2;
    tick();
    a_req_val = 0;
    chk("rdy_drop", {15'b0, a_req_rdy}, 16'd0);
    lat = 1;
    while (!a_resp_val && lat < 20) begin tick(); lat++; end
    chk("lat_basic", 16'(lat), 16'd2);
    chk("inst_basic", a_resp_inst, 16'h3333);
    tick();
    chk("val_one_cycle", {15'b0, a_resp_val}, 16'd0);
    chk("rdy_back", {15'b0, a_req_rdy}, 16'd1);

    // Backpressure for 5 cycles; a load to the captured address mid-hold must not leak through.
    a_resp_rdy = 0;
    req_a(8'd1, inst, lat);
    chk("lat_bp", 16'(lat), 16'd2);
    for (int i = 0; i < 5; i++) begin
      a_load_val = (i == 0); a_load_addr = 8'd1; a_load_data = 16'h5555;
      chk("bp_val", {15'b0, a_resp_val}, 16'd1);
      chk("bp_inst", a_resp_inst, 16'h2222);
      chk("bp_rdy", {15'b0, a_req_rdy}, 16'd0);
      tick();
    end
    a_load_val = 0;
    a_resp_rdy = 1;
    chk("bp_still_val", {15'b0, a_resp_val}, 16'd1);
    tick();
    chk("bp_release_val", {15'b0, a_resp_val}, 16'd0);
    chk("bp_release_rdy", {15'b0, a_req_rdy}, 16'd1);
    req_a(8'd1, inst, lat);
    chk("inst_after_load", inst, 16'h5555);
    tick();

    // Read-before-write on the accept edge.
    a_load_val = 1; a_load_addr = 8'd3; a_load_data = 16'hBEEF;
    req_a(8'd3, inst, lat);
    chk("rbw_old", inst, 16'h4444);
    tick();
    req_a(8'd3, inst, lat);
    chk("rbw_new", inst, 16'hBEEF);
    tick();

    // Out-of-range read (the earlier load to addr 8 was dropped).
    req_a(8'd8, inst, lat);
    chk("oor_inst", inst, 16'h0000);
    chk("oor_lat", 16'(lat), 16'd2);
    tick();

    // Reset mid-cycle while in WAIT.
    a_req_val = 1; a_req_addr = 8'd1;
    tick();
    a_req_val = 0;
    chk("wait_busy", {15'b0, a_busy}, 16'd1);
    #3 a_rst = 1;
    #1;
    chk("rstw_val", {15'b0, a_resp_val}, 16'd0);
    chk("rstw_rdy", {15'b0, a_req_rdy}, 16'd1);
    chk("rstw_busy", {15'b0, a_busy}, 16'd0);
    tick();
    a_rst = 0;
    tick();
    req_a(8'd0, inst, lat);
    chk("rstw_mem", inst, 16'h1111);
    tick();

    // Reset mid-cycle while holding a response.
    a_resp_rdy = 0;
    req_a(8'd2, inst, lat);
    chk("rstr_pre_val", {15'b0, a_resp_val}, 16'd1);
    #2 a_rst = 1;
    #1;
    chk("rstr_val", {15'b0, a_resp_val}, 16'd0);
    chk("rstr_rdy", {15'b0, a_req_rdy}, 16'd1);
    tick();
    a_rst = 0; a_resp_rdy = 1;
    tick();

    // Back-to-back fetches on B (LATENCY=1), fetcher-style: advance PC on each accept.
    pc = 0; got = 0; cyc = 0;
    b_req_val = 1; b_req_addr = 8'd0;
    while (got < 4 && cyc < 60) begin
      acc = b_req_val && b_req_rdy;
      tick();
      cyc++;
      if (acc) begin
        acc_cyc[pc] = cyc;
        pc++;
        if (pc == 4) b_req_val = 0;
        else b_req_addr = AW'(pc);
      end
      if (b_resp_val) begin
        rsp_inst[got] = b_resp_inst;
        rsp_cyc[got]  = cyc;
        got++;
      end
    end
    chk("b2b_count", 16'(got), 16'd4);
    for (int i = 0; i < got && i < pc; i++) begin
      chk($sformatf("b2b_inst%0d", i), rsp_inst[i], prog[i]);
      chk($sformatf("b2b_lat%0d", i), 16'(rsp_cyc[i] - acc_cyc[i] + 1), 16'd1);
      if (i > 0) chk($sformatf("b2b_space%0d", i), 16'(acc_cyc[i] - acc_cyc[i-1]), 16'd2);
    end
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
